rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered RV32/RV64 instruction decode stage between fetch and issue.
- Classifies the 5-bit major opcode, funct3 and funct7 into control flags, extracts register indices, and builds a sign-extended immediate.
- Flags illegal encodings.
- Buffers decoded records in a small FIFO with valid/ready handshakes on both sides, plus a flush input for redirects.

Parameters:
- XLEN, 32: datapath width, 32 or 64. 64 enables OP_32/OP_IMM_32, LD/LWU/SD and 6-bit shift amounts.
- BUF_DEPTH, 2: decoded-record FIFO depth, power of two, ≥2.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all buffered records and any same-cycle enqueue
- in_valid  in  1  fetch record valid
- in_ready  out  1  stage can accept a record
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  raw instruction
- out_valid  out  1  decoded record at FIFO head
- out_ready  in  1  consumer accepts head
- out_pc  out  XLEN  PC of head
- out_opcode  out  5  inst[6:2] of head
- out_funct3  out  3  inst[14:12]
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_flags  out  8  {illegal, is_load, is_store, is_branch, is_jump, uses_rs1, uses_rs2, writes_rd}
- illegal_count  out  CNT_W  saturating count of illegal records enqueued

Behaviour:
- Reset (async assert, sync release to clk):
  - FIFO count 0, pointers 0, out_valid 0, all out_* 0, illegal_count 0.
  - in_ready is 1 from the first clock edge after reset deasserts.
- Handshakes:
  - in_ready = (count < BUF_DEPTH), derived from registered count only; no combinational path from out_ready.
  - Enqueue when in_valid & in_ready & !flush. Dequeue when out_valid & out_ready.
  - Latency: a record enqueued at edge N is visible at the FIFO head from edge N+1 when the FIFO was empty.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - At full, in_ready is 0 even if out_ready is 1.
- Flush: on the next edge count=0 and out_valid=0. Flush overrides enqueue and dequeue in that cycle; illegal_count is unaffected by a flushed enqueue.
- Decode is combinational on in_inst, registered on enqueue. out_* hold stable while out_valid & !out_ready.
- Immediate formats, sign-extended from inst[31]:
  - I: LOAD, OP_IMM, JALR, OP_IMM_32, LOAD_FP.
  - S: STORE, STORE_FP.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, imm[11:0]=0.
  - J: JAL.
  - Others: 0.
- Flags:
  - is_load: LOAD, LOAD_FP.
  - is_store: STORE, STORE_FP.
  - is_branch: BRANCH.
  - is_jump: JAL, JALR.
  - uses_rs1: all formats except U, J and legal SYSTEM.
  - uses_rs2: R, S and B formats.
  - writes_rd: all except STORE*, BRANCH, MISC_MEM; rd==0 forces writes_rd=0.
- Illegal when any of:
  - inst[1:0]≠11.
  - Opcode not in the supported set.
  - LOAD funct3 ∉{000,001,010,100,101}; XLEN=64 also allows 011 and 110.
  - STORE funct3>010; XLEN=64 also allows 011.
  - BRANCH funct3 ∈{010,011}.
  - JALR funct3≠000.
  - OP_IMM SL with inst[31:25]≠0 (XLEN=32) or inst[31:26]≠0 (XLEN=64).
  - OP_IMM SR with upper bits not 0000000/0100000 (XLEN=64: 6-bit shamt, check inst[31:26] ∈{000000,010000}).
  - OP with funct7 ∉{0000000,0100000}, or 0100000 with funct3 ∉{000,101}.
  - OP_32/OP_IMM_32 when XLEN=32.
  - FP/MADD-family opcodes when FP decode is compiled out.
- Illegal records:
  - Still enqueued, with illegal=1 and all other flags 0.
  - illegal_count += 1 per illegal enqueue, saturating at all-ones.

Optional Feature:
- Macro: RV_DECODE_FP_EN.
- When defined: LOAD_FP and STORE_FP (funct3 010 legal, 011 legal only if XLEN=64), OP_FP, and MADD/MSUB/NMSUB/NMADD decode as legal.
  - MADD/MSUB/NMSUB/NMADD: uses_rs1/rs2=1, imm=0.
- When undefined: all these opcodes are illegal and no FP logic is generated.

Test Plan:
- XLEN=32, enqueue 0xFFF10093 (addi x1,x2,-1) → next cycle out_valid=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, flags=uses_rs1|writes_rd.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, is_branch=1, uses_rs1=uses_rs2=1, writes_rd=0.
- out_ready=0, offer 3 back-to-back records → first two accepted, in_ready=0 on the third; one dequeue → third accepted the following cycle; order preserved.
- Enqueue 0x00000000 then 0x0000009B (addiw, XLEN=32) → both illegal=1, illegal_count=2. With XLEN=64, 0x0000009B is legal and illegal_count=0.
- Two records buffered; assert flush together with in_valid → next cycle out_valid=0, count=0, illegal_count unchanged. Separately, assert rst mid-stream → out_valid=0 immediately.
- Enqueue 0x00002007 (flw) → with RV_DECODE_FP_EN: legal, is_load=1; without: illegal=1.

Source files
------------

// File: rtl/rv_decode_stage.sv
// Registered RV32/RV64 decode stage: classifies instructions, builds immediates, buffers records in a FIFO.
// Optional FP/MADD-family decode is enabled by defining RV_DECODE_FP_EN.
module rv_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [7:0]       out_flags,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam bit          RV64   = (XLEN == 64);

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;
`ifdef RV_DECODE_FP_EN
    localparam logic [4:0] OPC_LOAD_FP   = 5'b00001;
    localparam logic [4:0] OPC_STORE_FP  = 5'b01001;
    localparam logic [4:0] OPC_MADD      = 5'b10000;
    localparam logic [4:0] OPC_MSUB      = 5'b10001;
    localparam logic [4:0] OPC_NMSUB     = 5'b10010;
    localparam logic [4:0] OPC_NMADD     = 5'b10011;
    localparam logic [4:0] OPC_OP_FP     = 5'b10100;
`endif

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [7:0]      flags;
    } rec_t;

    logic [4:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            sl_bad, sr_bad, op_imm_ok;
    logic            legal, illegal;
    logic            is_load, is_store, is_branch, is_jump, uses_rs1, uses_rs2, writes_rd;
    logic [XLEN-1:0] imm;
    logic [7:0]      flags;
    rec_t            rec_d;

    assign opc    = in_inst[6:2];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd_idx = in_inst[11:7];

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    // RV64 shifts carry a 6-bit shamt, so only inst[31:26] qualifies the shift kind.
    assign sl_bad    = RV64 ? (in_inst[31:26] != 6'b000000)
                            : (f7 != 7'b0000000);
    assign sr_bad    = RV64 ? !((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000))
                            : !((f7 == 7'b0000000) || (f7 == 7'b0100000));
    assign op_imm_ok = !(((f3 == 3'b001) && sl_bad) || ((f3 == 3'b101) && sr_bad));

    always_comb begin
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        imm       = '0;
        case (opc)
            OPC_LOAD: begin
                legal     = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                            (RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
                is_load   = 1'b1;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_MISC_MEM: begin
                legal    = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_OP_IMM: begin
                legal     = op_imm_ok;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_AUIPC, OPC_LUI: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            OPC_OP_IMM_32: begin
                legal     = RV64;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_STORE: begin
                legal    = (f3 <= 3'b010) || (RV64 && (f3 == 3'b011));
                is_store = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = imm_s;
            end
            OPC_OP: begin
                legal     = (f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP_32: begin
                legal     = RV64;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                legal     = (f3 != 3'b010) && (f3 != 3'b011);
                is_branch = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm       = imm_b;
            end
            OPC_JALR: begin
                legal     = (f3 == 3'b000);
                is_jump   = 1'b1;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_JAL: begin
                legal     = 1'b1;
                is_jump   = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_j;
            end
            OPC_SYSTEM: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
            end
`ifdef RV_DECODE_FP_EN
            OPC_LOAD_FP: begin
                legal     = (f3 == 3'b010) || (RV64 && (f3 == 3'b011));
                is_load   = 1'b1;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_STORE_FP: begin
                legal    = (f3 == 3'b010) || (RV64 && (f3 == 3'b011));
                is_store = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = imm_s;
            end
            OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                legal     = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
`endif
            default: ;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    // Illegal records carry only the illegal flag.
    assign illegal = !legal;
    assign flags   = illegal ? 8'h80
                             : {1'b0, is_load, is_store, is_branch, is_jump,
                                uses_rs1, uses_rs2, writes_rd && (rd_idx != 5'd0)};

    assign rec_d = '{pc: in_pc, opcode: opc, funct3: f3, rd: rd_idx,
                     rs1: in_inst[19:15], rs2: in_inst[24:20], imm: imm, flags: flags};

    rec_t              mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic [CNT_W-1:0]  ill_q, ill_d;
    logic              ready_q, valid_q;
    logic              enq, deq;
    rec_t              head;

    assign enq = in_valid && ready_q && !flush;
    assign deq = valid_q && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ill_d    = ill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_FW'(1);
                2'b01:   count_d = count_q - CNT_FW'(1);
                default: ;
            endcase
            if (enq && illegal && (ill_q != '1)) begin
                ill_d = ill_q + CNT_W'(1);
            end
        end
    end

    // Ready/valid are registered from next-state count so neither depends combinationally on the far side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ill_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ill_q    <= ill_d;
            ready_q  <= (count_d < CNT_FW'(BUF_DEPTH));
            valid_q  <= (count_d != '0);
            if (enq) begin
                mem_q[wr_ptr_q] <= rec_d;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign in_ready      = ready_q;
    assign out_valid     = valid_q;
    assign out_pc        = head.pc;
    assign out_opcode    = head.opcode;
    assign out_funct3    = head.funct3;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_imm       = head.imm;
    assign out_flags     = head.flags;
    assign illegal_count = ill_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage (XLEN=32, depth 2, 2-bit illegal counter).
module tb_rv_decode_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic [7:0]       out_flags;
    logic [CNT_W-1:0] illegal_count;

    int n_tests;
    int n_fail;
    logic [CNT_W-1:0] exp_ill;

    rv_decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_flags(out_flags), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    task automatic test_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        n_tests++; if (illegal_count !== '0) begin n_fail++; $display("FAIL reset_illegal_count: got %0d exp 0", illegal_count); end
        n_tests++; if (out_pc !== '0 || out_flags !== 8'h00 || out_imm !== '0) begin
            n_fail++; $display("FAIL reset_out_fields: pc %0h flags %0h imm %0h exp all 0", out_pc, out_flags, out_imm);
        end
        rst = 1'b0;
        step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %0b exp 0", out_valid); end
    endtask

    task automatic test_addi();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'hFFF10093;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b exp 1", out_valid); end
        n_tests++; if (out_rd !== 5'd1 || out_rs1 !== 5'd2 || out_funct3 !== 3'd0) begin
            n_fail++; $display("FAIL addi_fields: rd %0d rs1 %0d f3 %0d exp 1 2 0", out_rd, out_rs1, out_funct3);
        end
        n_tests++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %0h exp ffffffff", out_imm); end
        n_tests++; if (out_flags !== 8'h05) begin n_fail++; $display("FAIL addi_flags: got %0h exp 05", out_flags); end
        n_tests++; if (out_pc !== 32'h100 || out_opcode !== 5'b00100) begin
            n_fail++; $display("FAIL addi_pc_opc: pc %0h opc %0b exp 100 00100", out_pc, out_opcode);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b exp 0", out_valid); end
    endtask

    task automatic test_branch();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h110; in_inst = 32'hFE000EE3;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %0h exp fffffffc", out_imm); end
        n_tests++; if (out_flags !== 8'h16) begin n_fail++; $display("FAIL beq_flags: got %0h exp 16", out_flags); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_decode_table();
        logic [31:0] v_inst [8] = '{32'h123452B7, 32'h008000EF, 32'h0020A223, 32'h4020D0B3,
                                    32'h00000073, 32'h00008067, 32'h40002033, 32'h02009093};
        logic [31:0] v_imm  [8] = '{32'h12345000, 32'h00000008, 32'h00000004, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h0};
        logic [7:0]  v_flg  [8] = '{8'h01, 8'h09, 8'h26, 8'h07, 8'h00, 8'h0C, 8'h80, 8'h80};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_inst = v_inst[i];
            if (v_flg[i][7]) exp_ill = sat_inc(exp_ill);
            step();
            n_tests++; if (out_valid !== 1'b1 || out_flags !== v_flg[i]) begin
                n_fail++; $display("FAIL table_flags[%0d]: valid %0b flags %0h exp 1 %0h", i, out_valid, out_flags, v_flg[i]);
            end
            if (!v_flg[i][7]) begin
                n_tests++; if (out_imm !== v_imm[i]) begin
                    n_fail++; $display("FAIL table_imm[%0d]: got %0h exp %0h", i, out_imm, v_imm[i]);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL table_drain: got %0b exp 0", out_valid); end
        n_tests++; if (illegal_count !== exp_ill) begin n_fail++; $display("FAIL table_illegal_count: got %0d exp %0d", illegal_count, exp_ill); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
        in_pc = 32'h200;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_empty: got %0b exp 1", in_ready); end
        step();
        in_pc = 32'h204;
        step();
        in_pc = 32'h208;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %0b exp 0", in_ready); end
        step();
        n_tests++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hold: pc %0h ready %0b exp 200 0", out_pc, in_ready);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_pc !== 32'h204 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_deq: pc %0h ready %0b exp 204 1", out_pc, in_ready);
        end
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0 || out_pc !== 32'h204) begin
            n_fail++; $display("FAIL b2b_third: ready %0b pc %0h exp 0 204", in_ready, out_pc);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h208) begin
            n_fail++; $display("FAIL b2b_order: valid %0b pc %0h exp 1 208", out_valid, out_pc);
        end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h00000000;
        exp_ill = sat_inc(exp_ill);
        step();
        n_tests++; if (out_flags !== 8'h80 || illegal_count !== exp_ill) begin
            n_fail++; $display("FAIL ill_zero: flags %0h count %0d exp 80 %0d", out_flags, illegal_count, exp_ill);
        end
        out_ready = 1'b1; in_pc = 32'h504; in_inst = 32'h0000009B;
        exp_ill = sat_inc(exp_ill);
        step();
        in_valid = 1'b0;
        n_tests++; if (out_pc !== 32'h504 || out_flags !== 8'h80) begin
            n_fail++; $display("FAIL ill_addiw: pc %0h flags %0h exp 504 80", out_pc, out_flags);
        end
        n_tests++; if (illegal_count !== 2'd3) begin n_fail++; $display("FAIL ill_saturate: got %0d exp 3", illegal_count); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
        in_pc = 32'h300; step();
        in_pc = 32'h304; step();
        in_pc = 32'h308; in_inst = 32'h00000000; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full: valid %0b ready %0b exp 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_pc = 32'h310; in_inst = 32'h00100093;
        step();
        in_pc = 32'h314; in_inst = 32'h00000000; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || illegal_count !== exp_ill) begin
            n_fail++; $display("FAIL flush_enq: valid %0b count %0d exp 0 %0d", out_valid, illegal_count, exp_ill);
        end
        in_valid = 1'b1; in_pc = 32'h320; in_inst = 32'h00100093;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h320) begin
            n_fail++; $display("FAIL flush_restart: valid %0b pc %0h exp 1 320", out_valid, out_pc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h00100093;
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        exp_ill = '0;
        n_tests++; if (out_valid !== 1'b0 || illegal_count !== '0) begin
            n_fail++; $display("FAIL rst_async: valid %0b count %0d exp 0 0", out_valid, illegal_count);
        end
        rst = 1'b0;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: ready %0b valid %0b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_fp();
        logic [7:0] exp_f;
`ifdef RV_DECODE_FP_EN
        exp_f = 8'h44;
`else
        exp_f = 8'h80;
        exp_ill = sat_inc(exp_ill);
`endif
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h700; in_inst = 32'h00002007;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_flags !== exp_f) begin n_fail++; $display("FAIL flw_flags: got %0h exp %0h", out_flags, exp_f); end
        n_tests++; if (illegal_count !== exp_ill) begin n_fail++; $display("FAIL flw_count: got %0d exp %0d", illegal_count, exp_ill); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_ill = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        #12;
        test_reset();
        test_addi();
        test_branch();
        test_decode_table();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_rst_mid();
        test_fp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
